sevens_table_reader: RTL and testbench

//   Read-side controller for the sevens EEPROM table used by base conversion.
//   On start, fetches LENGTH consecutive bytes beginning at BASE_ADDR by driving
//   the EEPROM's chip select, output enable and address lines, waits out the

---
 rtl/sevens_table_reader_if.sv | 31 +++
 rtl/sevens_table_reader.sv | 105 ++++++++++
 tb/tb_sevens_table_reader.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sevens_table_reader_if.sv
// Bundles the request/status port, the EEPROM read bus and the output byte stream of the
// sevens table reader.
interface sevens_table_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              ee_cs_n;
  logic              ee_oe_n;
  logic [ADDR_W-1:0] ee_addr;
  logic [DATA_W-1:0] ee_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  start, base_addr, length, ee_data, out_ready,
    output busy, done, ee_cs_n, ee_oe_n, ee_addr, out_data, out_valid, out_last
  );

  modport slave (
    output start, base_addr, length, ee_data, out_ready,
    input  busy, done, ee_cs_n, ee_oe_n, ee_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/sevens_table_reader.sv
// Fetches a run of bytes from the sevens EEPROM table, one access at a time, and streams
// each captured byte out over a valid/ready handshake.
module sevens_table_reader #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sevens_table_reader_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_PRESENT, S_FINISH} state_e;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [3:0]        wait_q, wait_d;
  logic              cs_n_q, cs_n_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      cs_n_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      cs_n_q  <= cs_n_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    cs_n_d  = cs_n_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.base_addr;
          rem_d   = bus.length;
          wait_d  = '0;
          state_d = (bus.length == '0) ? S_FINISH : S_ACCESS;
        end
      end
      S_ACCESS: begin
        // First cycle after start only selects the part; later accesses arrive already selected.
        if (cs_n_q) begin
          cs_n_d = 1'b0;
          wait_d = '0;
        end else if (wait_q == WAIT_LAST) begin
          data_d  = bus.ee_data;
          valid_d = 1'b1;
          cs_n_d  = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_PRESENT;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_PRESENT: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_ACCESS;
            cs_n_d  = 1'b0;
            wait_d  = '0;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q == S_ACCESS) || (state_q == S_PRESENT);
  assign bus.done      = (state_q == S_FINISH);
  assign bus.ee_cs_n   = cs_n_q;
  assign bus.ee_oe_n   = cs_n_q;
  assign bus.ee_addr   = addr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = valid_q && (rem_q == LEN_W'(1));

endmodule

// File: tb/tb_sevens_table_reader.sv
// Bench for sevens_table_reader: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance, each reading
// a shared EEPROM image, checked against an address/byte queue model on every negedge.
module tb_sevens_table_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ncyc      = 0;
  int sel_cycles = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  exp_q[$];
  logic [15:0] expa_q[$];
  logic [7:0]  got_q[$];
  logic [15:0] acc_addr_q[$];
  int          vrise_q[$];
  int          hs_q[$];
  int          done_q[$];
  logic        held_v [2];
  logic [7:0]  held_d [2];
  logic        prev_v [2];
  logic        prev_cs [2];

  sevens_table_reader_if #(.ADDR_W(16), .DATA_W(8), .LEN_W(16)) ifa ();
  sevens_table_reader_if #(.ADDR_W(16), .DATA_W(8), .LEN_W(16)) ifb ();

  sevens_table_reader #(.ADDR_W(16), .DATA_W(8), .LEN_W(16), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  sevens_table_reader #(.ADDR_W(16), .DATA_W(8), .LEN_W(16), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  // EEPROM drives a poison value whenever it is not selected.
  assign ifa.ee_data = (!ifa.ee_cs_n && !ifa.ee_oe_n) ? mem[ifa.ee_addr] : 8'hEE;
  assign ifb.ee_data = (!ifb.ee_cs_n && !ifb.ee_oe_n) ? mem[ifb.ee_addr] : 8'hEE;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  function automatic void fail(input string name, input string detail);
    total_cnt++;
    $display("FAIL %s: %s", name, detail);
  endfunction

  task automatic mon(input int i, input logic cs_n, input logic oe_n, input logic [15:0] addr,
                     input logic [7:0] data, input logic valid, input logic ready,
                     input logic last, input logic done, input logic busy);
    check("cs_oe_together", cs_n, oe_n);
    if (!cs_n) begin
      sel_cycles++;
      if (prev_cs[i]) acc_addr_q.push_back(addr);
      if (expa_q.size() == 0) fail("stray_access", $sformatf("got access at %0h, required none", addr));
      else check("ee_addr", addr, expa_q[0]);
    end
    if (valid) begin
      check("deselect_while_valid", cs_n, 1'b1);
      if (!prev_v[i]) vrise_q.push_back(ncyc);
      if (held_v[i]) check("held_data", data, held_d[i]);
      if (exp_q.size() == 0) begin
        fail("extra_beat", $sformatf("got byte %0h, required no beat", data));
      end else begin
        check("out_data", data, exp_q[0]);
        check("out_last", last, exp_q.size() == 1);
      end
      if (ready) begin
        got_q.push_back(data);
        hs_q.push_back(ncyc);
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(expa_q.pop_front());
        end
        held_v[i] = 1'b0;
      end else begin
        held_v[i] = 1'b1;
        held_d[i] = data;
      end
    end else begin
      check("last_without_valid", last, 1'b0);
      held_v[i] = 1'b0;
    end
    if (done) begin
      done_q.push_back(ncyc);
      check("busy_in_done", busy, 1'b0);
    end
    prev_v[i]  = valid;
    prev_cs[i] = cs_n;
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      mon(0, ifa.ee_cs_n, ifa.ee_oe_n, ifa.ee_addr, ifa.out_data, ifa.out_valid, ifa.out_ready,
          ifa.out_last, ifa.done, ifa.busy);
      mon(1, ifb.ee_cs_n, ifb.ee_oe_n, ifb.ee_addr, ifb.out_data, ifb.out_valid, ifb.out_ready,
          ifb.out_last, ifb.done, ifb.busy);
    end else begin
      for (int j = 0; j < 2; j++) begin
        held_v[j]  = 1'b0;
        prev_v[j]  = 1'b0;
        prev_cs[j] = 1'b1;
      end
    end
  end

  task automatic chk_rst(input string tag, input logic busy, input logic done, input logic cs_n,
                         input logic oe_n, input logic [15:0] addr, input logic valid,
                         input logic last, input logic [7:0] data);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_cs_n"}, cs_n, 1'b1);
    check({tag, "_oe_n"}, oe_n, 1'b1);
    check({tag, "_addr"}, addr, 16'h0000);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_last"}, last, 1'b0);
    check({tag, "_data"}, data, 8'h00);
  endtask

  task automatic clear_records();
    got_q.delete();
    acc_addr_q.delete();
    vrise_q.delete();
    hs_q.delete();
    done_q.delete();
    sel_cycles = 0;
  endtask

  task automatic load_model(input logic [15:0] base, input logic [15:0] len);
    for (int j = 0; j < int'(len); j++) begin
      logic [15:0] a;
      a = base + 16'(j);
      exp_q.push_back(mem[a]);
      expa_q.push_back(a);
    end
  endtask

  // Issues one request; k_idx is the negedge index just after the edge that accepts start.
  task automatic run(input int i, input logic [15:0] base, input logic [15:0] len,
                     input int stall_hs, input int stall_n, output int k_idx);
    int   left;
    logic v;
    left = stall_n;
    load_model(base, len);
    clear_records();
    @(posedge clk); #1;
    if (i == 0) begin ifa.start = 1'b1; ifa.base_addr = base; ifa.length = len; end
    else        begin ifb.start = 1'b1; ifb.base_addr = base; ifb.length = len; end
    k_idx = ncyc + 2;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    for (int c = 0; c < 400 && done_q.size() == 0; c++) begin
      v = (i == 0) ? ifa.out_valid : ifb.out_valid;
      if (left > 0 && v && hs_q.size() == stall_hs) begin
        left--;
        if (i == 0) ifa.out_ready = 1'b0; else ifb.out_ready = 1'b0;
      end else begin
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    if (done_q.size() == 0) fail("timeout", "got no done pulse, required one within 400 cycles");
    check("bytes_streamed", got_q.size(), len);
    check("model_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    check("single_done", done_q.size(), 1);
  endtask

  task automatic chk_timing(input string tag, input int k_idx, input int first, input int period);
    if (vrise_q.size() == 0 || hs_q.size() == 0 || done_q.size() == 0) begin
      fail({tag, "_timing"}, "got no beats or done, required a full stream");
    end else begin
      check({tag, "_first_valid"}, vrise_q[0] - k_idx, first);
      for (int j = 1; j < vrise_q.size(); j++)
        check({tag, "_beat_period"}, vrise_q[j] - vrise_q[j-1], period);
      check({tag, "_done_after_hs"}, done_q[0] - hs_q[hs_q.size()-1], 1);
    end
  endtask

  initial begin
    int          k;
    logic [7:0]  lit5 [5];
    logic [7:0]  lit2 [2];
    logic [15:0] lita [3];
    lit5 = '{8'h01, 8'h03, 8'h07, 8'h0C, 8'h1C};
    lit2 = '{8'h34, 8'h7A};
    lita = '{16'hFFFE, 16'hFFFF, 16'h0000};

    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 37 + 11);
    mem[0] = 8'h01; mem[1] = 8'h03; mem[2] = 8'h07; mem[3] = 8'h0C; mem[4] = 8'h1C;
    mem[5] = 8'h34; mem[6] = 8'h7A;
    mem[16'hFFFE] = 8'hA5; mem[16'hFFFF] = 8'h5A;

    ifa.start = 1'b0; ifa.base_addr = '0; ifa.length = '0; ifa.out_ready = 1'b1;
    ifb.start = 1'b0; ifb.base_addr = '0; ifb.length = '0; ifb.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk_rst("rstA", ifa.busy, ifa.done, ifa.ee_cs_n, ifa.ee_oe_n, ifa.ee_addr, ifa.out_valid,
            ifa.out_last, ifa.out_data);
    chk_rst("rstB", ifb.busy, ifb.done, ifb.ee_cs_n, ifb.ee_oe_n, ifb.ee_addr, ifb.out_valid,
            ifb.out_last, ifb.out_data);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic stream, ready held high.
    run(0, 16'h0000, 16'd5, 0, 0, k);
    chk_timing("basic", k, 4, 4);
    check("basic_sel_cycles", sel_cycles, 15);
    if (got_q.size() == 5) for (int j = 0; j < 5; j++) check("basic_byte", got_q[j], lit5[j]);

    // Backpressure on byte 2, plus a start pulse while busy that must be ignored.
    fork
      begin
        wait (ifa.busy === 1'b1);
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.base_addr = 16'h0040; ifa.length = 16'd1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
      end
      run(0, 16'h0000, 16'd5, 1, 6, k);
    join
    if (got_q.size() == 5) for (int j = 0; j < 5; j++) check("stall_byte", got_q[j], lit5[j]);
    repeat (4) @(posedge clk);

    // Zero-length request.
    run(0, 16'h0000, 16'd0, 0, 0, k);
    if (done_q.size() > 0) check("len0_done_cycle", done_q[0] - k, 0);
    check("len0_no_access", sel_cycles, 0);
    check("len0_no_valid", vrise_q.size(), 0);

    // Address wrap.
    run(0, 16'hFFFE, 16'd3, 0, 0, k);
    check("wrap_accesses", acc_addr_q.size(), 3);
    if (acc_addr_q.size() == 3) for (int j = 0; j < 3; j++) check("wrap_addr", acc_addr_q[j], lita[j]);
    if (got_q.size() == 3) check("wrap_byte_last", got_q[2], mem[0]);

    // Reset mid-request after a ignored start pulse.
    load_model(16'h0000, 16'd5);
    clear_records();
    @(posedge clk); #1;
    ifa.start = 1'b1; ifa.base_addr = 16'h0000; ifa.length = 16'd5;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    for (int c = 0; c < 100 && !(hs_q.size() == 1 && ifa.ee_cs_n === 1'b0); c++) begin
      if (ifa.out_valid && hs_q.size() == 0) begin
        ifa.start = 1'b1; ifa.base_addr = 16'h0040; ifa.length = 16'd1;
      end else begin
        ifa.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    ifa.start = 1'b0;
    check("rst_reached_2nd_access", ifa.ee_cs_n, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    expa_q.delete();
    @(posedge clk); #1;
    chk_rst("midrst", ifa.busy, ifa.done, ifa.ee_cs_n, ifa.ee_oe_n, ifa.ee_addr, ifa.out_valid,
            ifa.out_last, ifa.out_data);
    @(posedge clk); #1;
    rst = 1'b0;
    done_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_done", done_q.size(), 0);
    check("midrst_bytes_before", got_q.size(), 1);

    run(0, 16'h0000, 16'd5, 0, 0, k);
    chk_timing("after_rst", k, 4, 4);
    if (got_q.size() == 5) check("after_rst_last_byte", got_q[4], 8'h1C);

    // Zero-wait build.
    run(1, 16'h0005, 16'd2, 0, 0, k);
    chk_timing("wait0", k, 2, 2);
    check("wait0_sel_cycles", sel_cycles, 2);
    if (got_q.size() == 2) for (int j = 0; j < 2; j++) check("wait0_byte", got_q[j], lit2[j]);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
